// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with ID/EX register and load-use bubble insertion
module decode_stage #(
    parameter int OPW  = 3,
    parameter int RW   = 3,
    parameter int IMMW = 8,
    parameter int CNTW = 8
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    input  logic [RW-1:0]   in_rd,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic [IMMW-1:0] in_imm,
    input  logic            flush,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            out_regwrite,
    output logic            out_alusrc,
    output logic            out_memw,
    output logic            out_reg2mem,
    output logic [1:0]      out_aluop,
    output logic [RW-1:0]   out_rd,
    output logic [RW-1:0]   out_rs1,
    output logic [RW-1:0]   out_rs2,
    output logic [IMMW-1:0] out_imm,
    output logic            out_illegal,
    output logic [CNTW-1:0] stall_count
);
    localparam logic [2:0] OP_ADD = 3'd0, OP_ADDI = 3'd1, OP_SW = 3'd2, OP_LW = 3'd3,
                           OP_SLL = 3'd4, OP_SUB = 3'd5, OP_SRL = 3'd6;

    logic            valid_q, valid_d, regwrite_q, regwrite_d, alusrc_q, alusrc_d;
    logic            memw_q, memw_d, reg2mem_q, reg2mem_d, illegal_q, illegal_d;
    logic [1:0]      aluop_q, aluop_d;
    logic [RW-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [IMMW-1:0] imm_q, imm_d;
    logic [CNTW-1:0] stall_q, stall_d;

    logic       dec_illegal, dec_regwrite, dec_alusrc, dec_memw, dec_reg2mem;
    logic       rs1_used, rs2_used, hazard;
    logic [1:0] dec_aluop;

    always_comb begin
        dec_illegal  = (in_op > OPW'(7));
        dec_regwrite = 1'b0;
        dec_alusrc   = 1'b0;
        dec_memw     = 1'b0;
        dec_reg2mem  = 1'b0;
        dec_aluop    = 2'b00;
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        if (!dec_illegal) begin
            rs1_used = 1'b1;
            case (in_op[2:0])
                OP_ADD:  begin dec_regwrite = 1'b1; rs2_used = 1'b1; end
                OP_ADDI: begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; end
                OP_SW:   begin dec_alusrc = 1'b1; dec_memw = 1'b1; rs2_used = 1'b1; end
                OP_LW:   begin dec_regwrite = 1'b1; dec_alusrc = 1'b1; dec_reg2mem = 1'b1; end
                OP_SLL:  begin dec_regwrite = 1'b1; dec_aluop = 2'b01; rs2_used = 1'b1; end
                OP_SUB:  begin dec_regwrite = 1'b1; dec_aluop = 2'b10; rs2_used = 1'b1; end
                OP_SRL:  begin dec_regwrite = 1'b1; dec_aluop = 2'b11; rs2_used = 1'b1; end
                default: rs1_used = 1'b0;
            endcase
        end
    end

    // Register counts as empty while reset is asserted, so no hazard can block acceptance.
    assign hazard = !reset && valid_q && reg2mem_q && in_valid && (rd_q != '0) &&
                    ((rs1_used && rd_q == in_rs1) || (rs2_used && rd_q == in_rs2));
    assign in_ready = flush || (out_ready && !hazard);

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        alusrc_d   = alusrc_q;
        memw_d     = memw_q;
        reg2mem_d  = reg2mem_q;
        aluop_d    = aluop_q;
        illegal_d  = illegal_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        stall_d    = stall_q;
        if (reset || flush || (out_ready && (hazard || !in_valid))) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            alusrc_d   = 1'b0;
            memw_d     = 1'b0;
            reg2mem_d  = 1'b0;
            aluop_d    = 2'b00;
            illegal_d  = 1'b0;
        end
        if (reset) begin
            rd_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            imm_d   = '0;
            stall_d = '0;
        end else if (!flush && out_ready) begin
            if (hazard) begin
                if (stall_q != '1)
                    stall_d = stall_q + 1'b1;
            end else if (in_valid) begin
                valid_d    = 1'b1;
                regwrite_d = dec_regwrite;
                alusrc_d   = dec_alusrc;
                memw_d     = dec_memw;
                reg2mem_d  = dec_reg2mem;
                aluop_d    = dec_aluop;
                illegal_d  = dec_illegal;
                rd_d       = in_rd;
                rs1_d      = in_rs1;
                rs2_d      = in_rs2;
                imm_d      = in_imm;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        valid_q    <= valid_d;
        regwrite_q <= regwrite_d;
        alusrc_q   <= alusrc_d;
        memw_q     <= memw_d;
        reg2mem_q  <= reg2mem_d;
        aluop_q    <= aluop_d;
        illegal_q  <= illegal_d;
        rd_q       <= rd_d;
        rs1_q      <= rs1_d;
        rs2_q      <= rs2_d;
        imm_q      <= imm_d;
        stall_q    <= stall_d;
    end

    assign out_valid    = valid_q;
    assign out_regwrite = regwrite_q;
    assign out_alusrc   = alusrc_q;
    assign out_memw     = memw_q;
    assign out_reg2mem  = reg2mem_q;
    assign out_aluop    = aluop_q;
    assign out_illegal  = illegal_q;
    assign out_rd       = rd_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_imm      = imm_q;
    assign stall_count  = stall_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
    localparam int OPW = 4, RW = 3, IMMW = 8, CNTW = 8;
    localparam logic [OPW-1:0] ADD = 0, ADDI = 1, SW = 2, LW = 3, SLL = 4, SUB = 5, SRL = 6, NOP = 7;

    logic            sysclk = 1'b0;
    logic            reset, in_valid, flush, out_ready;
    logic            in_ready, out_valid, out_regwrite, out_alusrc, out_memw, out_reg2mem, out_illegal;
    logic [OPW-1:0]  in_op;
    logic [RW-1:0]   in_rd, in_rs1, in_rs2, out_rd, out_rs1, out_rs2;
    logic [IMMW-1:0] in_imm, out_imm;
    logic [1:0]      out_aluop;
    logic [CNTW-1:0] stall_count;

    int total = 0;
    int bad   = 0;

    decode_stage #(.OPW(OPW), .RW(RW), .IMMW(IMMW), .CNTW(CNTW)) dut (
        .sysclk(sysclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_regwrite(out_regwrite), .out_alusrc(out_alusrc), .out_memw(out_memw),
        .out_reg2mem(out_reg2mem), .out_aluop(out_aluop), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_illegal(out_illegal), .stall_count(stall_count)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [OPW-1:0] op, input logic [RW-1:0] rd,
                         input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input logic [IMMW-1:0] imm);
        in_valid = v; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        #1;
    endtask

    // Expected {valid, regwrite, alusrc, memw, reg2mem, aluop, illegal}
    task automatic check_ctl(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, out_valid, out_regwrite, out_alusrc, out_memw, out_reg2mem, out_aluop, out_illegal}, {24'd0, exp});
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, LW, 3'd3, 3'd3, 3'd3, 8'hAA);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); tick();
        check_ctl("reset_ctl", 8'b0_0000_00_0);
        check("reset_stall", stall_count, 0);
        check("reset_imm", out_imm, 0);
        reset = 1'b0;

        drive(1'b1, ADDI, 3'd2, 3'd1, 3'd0, 8'd5);
        check("addi_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_ctl("addi_ctl", 8'b1_1100_00_0);
        check("addi_imm", out_imm, 5);
        check("addi_rd", out_rd, 2);

        drive(1'b1, LW, 3'd3, 3'd1, 3'd0, 8'd4);
        tick();
        check_ctl("lw_ctl", 8'b1_1101_00_0);
        drive(1'b1, ADD, 3'd4, 3'd3, 3'd1, 8'd0);
        check("loaduse_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check_ctl("bubble_ctl", 8'b0_0000_00_0);
        check("bubble_stall", stall_count, 1);
        check("after_bubble_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_ctl("add_ctl", 8'b1_1000_00_0);
        check("add_rd", out_rd, 4);

        drive(1'b1, LW, 3'd0, 3'd1, 3'd0, 8'd0);
        tick();
        drive(1'b1, ADD, 3'd5, 3'd0, 3'd0, 8'd0);
        check("lw_r0_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("lw_r0_rd", out_rd, 5);
        check("lw_r0_stall", stall_count, 1);

        drive(1'b1, SUB, 3'd6, 3'd2, 3'd3, 8'd0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, SLL, 3'd7, 3'd1, 3'd2, 8'd9);
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            check_ctl("hold_ctl", 8'b1_1000_10_0);
            check("hold_rd", out_rd, 6);
        end
        out_ready = 1'b1;
        #1;
        tick();
        check_ctl("sll_ctl", 8'b1_1000_01_0);
        check("sll_rd", out_rd, 7);

        drive(1'b1, SRL, 3'd1, 3'd2, 3'd3, 8'd0);
        tick();
        check_ctl("srl_ctl", 8'b1_1000_11_0);
        drive(1'b1, SW, 3'd0, 3'd1, 3'd2, 8'd8);
        tick();
        check_ctl("sw_ctl", 8'b1_0110_00_0);
        drive(1'b1, NOP, 3'd0, 3'd0, 3'd0, 8'd0);
        tick();
        check_ctl("nop_ctl", 8'b1_0000_00_0);
        drive(1'b1, 4'd9, 3'd3, 3'd1, 3'd2, 8'd0);
        tick();
        check_ctl("illegal_ctl", 8'b1_0000_00_1);
        drive(1'b0, ADD, 3'd0, 3'd0, 3'd0, 8'd0);
        tick();
        check_ctl("idle_ctl", 8'b0_0000_00_0);

        drive(1'b1, LW, 3'd3, 3'd1, 3'd0, 8'd0);
        tick();
        drive(1'b1, ADD, 3'd4, 3'd3, 3'd1, 8'd0);
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        flush = 1'b0;
        check_ctl("flush_ctl", 8'b0_0000_00_0);
        check("flush_stall", stall_count, 1);

        drive(1'b1, LW, 3'd3, 3'd3, 3'd0, 8'd0);
        tick();
        for (int i = 0; i < 254; i++) begin
            tick();
            tick();
        end
        check("sat_reach", stall_count, 255);
        check_ctl("sat_lw_ctl", 8'b1_1101_00_0);
        tick();
        check("sat_hold", stall_count, 255);
        check_ctl("sat_bubble_ctl", 8'b0_0000_00_0);
        tick();
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("reset_stall_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_ctl("midstall_reset_ctl", 8'b0_0000_00_0);
        check("midstall_reset_stall", stall_count, 0);
        check("midstall_reset_rd", out_rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
